rvfi_channel_serializer: RTL and testbench
==========================================

// Module: rvfi_channel_serializer
// PURPOSE
//  Sequencer in front of a single-channel instruction checker for NRET-wide cores.
//  - Captures up to NRET retirements per cycle from the packed RVFI bus.
//  - Buffers them in program order.
//  - Replays them one per cycle over a valid/ready handshake, so the checker runs with NRET=1.
// PARAMETERS
//  XLEN   32  register/PC width
//  NRET   1   retirement channels on input bus
//  DEPTH  8   buffer entries; power of 2, DEPTH >= NRET
// PORTS
//  clk              in   1          clock, rising edge
//  resetn           in   1          async active-low reset
//  rvfi_valid       in   NRET       per-channel retire valid
//  rvfi_insn        in   NRET*32    instruction word
//  rvfi_rs1/rs2/rd  in   NRET*5     register addresses
//  rvfi_pre_pc      in   NRET*XLEN  PC before insn
//  rvfi_pre_rs1/2   in   NRET*XLEN  source operand values
//  rvfi_post_pc     in   NRET*XLEN  PC after insn
//  rvfi_post_rd     in   NRET*XLEN  rd writeback value
//  rvfi_post_trap   in   NRET       trap flag
//  in_ready         out  1          buffer can take a full bundle this cycle
//  out_valid        out  1          out_* holds a buffered retirement
//  out_ready        in   1          checker consumes out_* this cycle
//  out_insn,out_rs1,out_rs2,out_rd,out_pre_pc,out_pre_rs1,out_pre_rs2,
//  out_post_pc,out_post_rd,out_post_trap  out  1-channel widths as above
//  level            out  $clog2(DEPTH)+1  occupied entries
//  overflow         out  1          sticky: bundle dropped
// BEHAVIOUR
//  Reset (async, resetn=0):
//  - wr_ptr=rd_ptr=0, level=0, out_valid=0, overflow=0.
//  - Storage is not reset; out_* are don't-care while out_valid=0.
//  Input side:
//  - k = popcount(rvfi_valid).
//  - in_ready = (DEPTH-level) >= NRET, from registered level only; a same-cycle pop is not credited.
//  - Push: in_ready && k>0. Valid channels are written in ascending channel index (program order)
//    to slots wr_ptr, wr_ptr+1, ... modulo DEPTH. Invalid channels are skipped (compaction).
//  - wr_ptr += k, modulo DEPTH.
//  - k>0 && !in_ready: the whole bundle is dropped, never partially written; overflow<=1 until reset.
//  Output side:
//  - out_valid = (level!=0).
//  - out_* = entry[rd_ptr], combinational from storage. Zero-latency first word: a push at edge N
//    gives out_valid=1 in cycle N+1.
//  - Pop: out_valid && out_ready. rd_ptr += 1 modulo DEPTH.
//  - While out_valid && !out_ready, out_* hold stable.
//  Occupancy:
//  - level_next = level + (push ? k : 0) - (pop ? 1 : 0).
//  - Simultaneous push and pop is legal. level never exceeds DEPTH and never underflows.
//  Boundaries:
//  - Pointer wrap: a compacted bundle may straddle entry DEPTH-1 -> 0.
//  - Full: level=DEPTH forces in_ready=0 and out_valid=1.
//  - Empty: out_ready is ignored.
//  - Reset mid-burst discards all entries immediately.
//  Throughput: 1 retirement/cycle out. Sustained input above 1/cycle eventually deasserts in_ready.
// CONFIGURATION
//  RVFI_SERIALIZER_ORDER_CHECK_EN defined:
//  - Adds registered last_post_pc / last_vld, set on each pop.
//  - Adds output order_error (1 bit, sticky, reset 0).
//  - order_error sets when a popped entry has pre_pc != last_post_pc while last_vld=1 and the
//    previous popped entry had post_trap=0.
//  - A trap entry re-arms the check: the next pop only loads last_post_pc, no compare.
//  - With -DFORMAL also asserts !order_error.
//  Undefined: port order_error is absent; no extra state.
// TESTING
//  1 NRET=1, DEPTH=4; single retire pc=0x100 insn=0x00000013, out_ready=1 -> out_valid next cycle,
//    out_pre_pc=0x100, level 1->0.
//  2 NRET=2; rvfi_valid=2'b11 pcs 0x200/0x204, out_ready=1 -> outputs 0x200 then 0x204 on
//    consecutive cycles.
//  3 NRET=2; rvfi_valid=2'b10 pc1=0x300 -> one entry, out_pre_pc=0x300, level=1.
//  4 NRET=2, DEPTH=4; out_ready=0, three bundles 2'b11 -> third dropped, overflow=1, level=4,
//    in_ready=0. Drain returns first four pcs in order.
//  5 DEPTH=4; wr_ptr=3, push 2'b11 -> entries land in slots 3,0, read order preserved across wrap.
//  6 ORDER_CHECK_EN; pops pc 0x0->post 0x4, then pre_pc 0x8 -> order_error=1. With trap on the
//    first entry -> order_error stays 0.
//  7 resetn=0 pulse with level=3 -> level=0, out_valid=0 asynchronously; overflow cleared.

Source files
------------

// File: rtl/rvfi_channel_serializer.sv
// Serializes up to NRET RVFI retirements/cycle into a 1-wide valid/ready stream, program order kept.
// Latency: push at edge N -> out_valid in cycle N+1; in_ready from registered level (full bundle must fit).
// Optional RVFI_SERIALIZER_ORDER_CHECK_EN adds sticky order_error (pre_pc vs previous post_pc).
module rvfi_channel_serializer #(
  parameter int XLEN  = 32,
  parameter int NRET  = 1,
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [NRET*32-1:0]   rvfi_insn,
  input  logic [NRET*5-1:0]    rvfi_rs1,
  input  logic [NRET*5-1:0]    rvfi_rs2,
  input  logic [NRET*5-1:0]    rvfi_rd,
  input  logic [NRET*XLEN-1:0] rvfi_pre_pc,
  input  logic [NRET*XLEN-1:0] rvfi_pre_rs1,
  input  logic [NRET*XLEN-1:0] rvfi_pre_rs2,
  input  logic [NRET*XLEN-1:0] rvfi_post_pc,
  input  logic [NRET*XLEN-1:0] rvfi_post_rd,
  input  logic [NRET-1:0]      rvfi_post_trap,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_insn,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [4:0]           out_rd,
  output logic [XLEN-1:0]      out_pre_pc,
  output logic [XLEN-1:0]      out_pre_rs1,
  output logic [XLEN-1:0]      out_pre_rs2,
  output logic [XLEN-1:0]      out_post_pc,
  output logic [XLEN-1:0]      out_post_rd,
  output logic                 out_post_trap,
  output logic [$clog2(DEPTH):0] level,
  output logic                 overflow
`ifdef RVFI_SERIALIZER_ORDER_CHECK_EN
  ,
  output logic                 order_error
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [31:0]     insn;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pre_pc;
    logic [XLEN-1:0] pre_rs1;
    logic [XLEN-1:0] pre_rs2;
    logic [XLEN-1:0] post_pc;
    logic [XLEN-1:0] post_rd;
    logic            post_trap;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          in_ent [NRET];
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   k;
  logic [LW-1:0]   off [NRET];
  logic [LW-1:0]   level_next;
  logic            push;
  logic            pop;

  always_comb begin
    for (int i = 0; i < NRET; i++) begin
      in_ent[i].insn      = rvfi_insn[i*32 +: 32];
      in_ent[i].rs1       = rvfi_rs1[i*5 +: 5];
      in_ent[i].rs2       = rvfi_rs2[i*5 +: 5];
      in_ent[i].rd        = rvfi_rd[i*5 +: 5];
      in_ent[i].pre_pc    = rvfi_pre_pc[i*XLEN +: XLEN];
      in_ent[i].pre_rs1   = rvfi_pre_rs1[i*XLEN +: XLEN];
      in_ent[i].pre_rs2   = rvfi_pre_rs2[i*XLEN +: XLEN];
      in_ent[i].post_pc   = rvfi_post_pc[i*XLEN +: XLEN];
      in_ent[i].post_rd   = rvfi_post_rd[i*XLEN +: XLEN];
      in_ent[i].post_trap = rvfi_post_trap[i];
    end
  end

  // off[i] = number of valid channels below i: the compacted slot offset of channel i
  always_comb begin
    k = '0;
    for (int i = 0; i < NRET; i++) begin
      off[i] = k;
      k      = k + LW'(rvfi_valid[i]);
    end
  end

  assign in_ready   = (LW'(DEPTH) - level) >= LW'(NRET);
  assign push       = in_ready && (k != '0);
  assign out_valid  = (level != '0);
  assign pop        = out_valid && out_ready;
  assign level_next = level + (push ? k : '0) - LW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < NRET; i++) begin
        if (rvfi_valid[i]) mem[wr_ptr + AW'(off[i])] <= in_ent[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(k);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_next;
      if ((k != '0) && !in_ready) overflow <= 1'b1;
    end
  end

  assign head          = mem[rd_ptr];
  assign out_insn      = head.insn;
  assign out_rs1       = head.rs1;
  assign out_rs2       = head.rs2;
  assign out_rd        = head.rd;
  assign out_pre_pc    = head.pre_pc;
  assign out_pre_rs1   = head.pre_rs1;
  assign out_pre_rs2   = head.pre_rs2;
  assign out_post_pc   = head.post_pc;
  assign out_post_rd   = head.post_rd;
  assign out_post_trap = head.post_trap;

`ifdef RVFI_SERIALIZER_ORDER_CHECK_EN
  logic [XLEN-1:0] last_post_pc;
  logic            last_vld;
  logic            last_trap;

  // A trapped predecessor leaves the next pc unconstrained, so that pop only reloads
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_post_pc <= '0;
      last_vld     <= 1'b0;
      last_trap    <= 1'b0;
      order_error  <= 1'b0;
    end else if (pop) begin
      if (last_vld && !last_trap && (head.pre_pc != last_post_pc)) order_error <= 1'b1;
      last_post_pc <= head.post_pc;
      last_vld     <= 1'b1;
      last_trap    <= head.post_trap;
    end
  end

`ifdef FORMAL
  always @(posedge clk) begin
    if (resetn) assert (!order_error);
  end
`endif
`endif

endmodule

// File: tb/tb_rvfi_channel_serializer.sv
// Directed table-driven bench for rvfi_channel_serializer at NRET=2, DEPTH=4.
module tb_rvfi_channel_serializer;
  localparam int XLEN  = 32;
  localparam int NRET  = 2;
  localparam int DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic [NRET-1:0]      rvfi_valid;
  logic [NRET*32-1:0]   rvfi_insn;
  logic [NRET*5-1:0]    rvfi_rs1, rvfi_rs2, rvfi_rd;
  logic [NRET*XLEN-1:0] rvfi_pre_pc, rvfi_pre_rs1, rvfi_pre_rs2, rvfi_post_pc, rvfi_post_rd;
  logic [NRET-1:0]      rvfi_post_trap;
  logic                 in_ready, out_valid, out_ready;
  logic [31:0]          out_insn;
  logic [4:0]           out_rs1, out_rs2, out_rd;
  logic [XLEN-1:0]      out_pre_pc, out_pre_rs1, out_pre_rs2, out_post_pc, out_post_rd;
  logic                 out_post_trap;
  logic [2:0]           level;
  logic                 overflow;
`ifdef RVFI_SERIALIZER_ORDER_CHECK_EN
  logic                 order_error;
`endif

  int errors = 0;
  int checks = 0;
  logic [1:0] trap_bits = 2'b00;

  rvfi_channel_serializer #(.XLEN(XLEN), .NRET(NRET), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .rvfi_valid(rvfi_valid), .rvfi_insn(rvfi_insn),
    .rvfi_rs1(rvfi_rs1), .rvfi_rs2(rvfi_rs2), .rvfi_rd(rvfi_rd),
    .rvfi_pre_pc(rvfi_pre_pc), .rvfi_pre_rs1(rvfi_pre_rs1), .rvfi_pre_rs2(rvfi_pre_rs2),
    .rvfi_post_pc(rvfi_post_pc), .rvfi_post_rd(rvfi_post_rd), .rvfi_post_trap(rvfi_post_trap),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_insn(out_insn), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_pre_pc(out_pre_pc), .out_pre_rs1(out_pre_rs1), .out_pre_rs2(out_pre_rs2),
    .out_post_pc(out_post_pc), .out_post_rd(out_post_rd), .out_post_trap(out_post_trap),
    .level(level), .overflow(overflow)
`ifdef RVFI_SERIALIZER_ORDER_CHECK_EN
    , .order_error(order_error)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  vld;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic        rdy;
    logic        exp_vld;
    logic [31:0] exp_pc;
    logic [2:0]  exp_lvl;
    logic        exp_ir;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [1:0] vld, logic [31:0] pc0, logic [31:0] pc1, logic rdy,
                              logic ev, logic [31:0] epc, logic [2:0] el, logic eir, logic eovf);
    vec_t v;
    v.vld = vld; v.pc0 = pc0; v.pc1 = pc1; v.rdy = rdy;
    v.exp_vld = ev; v.exp_pc = epc; v.exp_lvl = el; v.exp_ir = eir; v.exp_ovf = eovf;
    return v;
  endfunction

  function automatic logic [31:0] insn_of(logic [31:0] pc);
    return pc ^ 32'h0000_0013;
  endfunction

  function automatic logic [4:0] rd_of(logic [31:0] pc);
    return pc[8:4];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic [1:0] vld, logic [31:0] pc0, logic [31:0] pc1);
    rvfi_valid     = vld;
    rvfi_pre_pc    = {pc1, pc0};
    rvfi_post_pc   = {pc1 + 32'd4, pc0 + 32'd4};
    rvfi_insn      = {insn_of(pc1), insn_of(pc0)};
    rvfi_rs1       = {pc1[6:2], pc0[6:2]};
    rvfi_rs2       = {pc1[7:3], pc0[7:3]};
    rvfi_rd        = {rd_of(pc1), rd_of(pc0)};
    rvfi_pre_rs1   = {~pc1, ~pc0};
    rvfi_pre_rs2   = {pc1 + 32'd1, pc0 + 32'd1};
    rvfi_post_rd   = {pc1 + 32'd2, pc0 + 32'd2};
    rvfi_post_trap = trap_bits;
  endtask

  task automatic step(vec_t v, int idx);
    drive(v.vld, v.pc0, v.pc1);
    out_ready = v.rdy;
    @(posedge clk);
    #1;
    check($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'(v.exp_vld));
    check($sformatf("v%0d level", idx), 32'(level), 32'(v.exp_lvl));
    check($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(v.exp_ir));
    check($sformatf("v%0d overflow", idx), 32'(overflow), 32'(v.exp_ovf));
    if (v.exp_vld) begin
      check($sformatf("v%0d out_pre_pc", idx), out_pre_pc, v.exp_pc);
      check($sformatf("v%0d out_post_pc", idx), out_post_pc, v.exp_pc + 32'd4);
      check($sformatf("v%0d out_insn", idx), out_insn, insn_of(v.exp_pc));
      check($sformatf("v%0d out_rd", idx), 32'(out_rd), 32'(rd_of(v.exp_pc)));
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    resetn = 1'b0;
    drive(2'b00, 32'h0, 32'h0);
    out_ready = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    out_ready = 1'b0;
    drive(2'b00, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset level", 32'(level), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset overflow", 32'(overflow), 32'd0);

    // single retire
    tbl.push_back(mk(2'b01, 32'h100, 32'h0,   1, 1, 32'h100, 3'd1, 1, 0));
    tbl.push_back(mk(2'b00, 32'h0,   32'h0,   1, 0, 32'h0,   3'd0, 1, 0));
    // dual retire, consecutive output
    tbl.push_back(mk(2'b11, 32'h200, 32'h204, 1, 1, 32'h200, 3'd2, 1, 0));
    tbl.push_back(mk(2'b00, 32'h0,   32'h0,   1, 1, 32'h204, 3'd1, 1, 0));
    tbl.push_back(mk(2'b00, 32'h0,   32'h0,   1, 0, 32'h0,   3'd0, 1, 0));
    // compaction: only channel 1 valid
    tbl.push_back(mk(2'b10, 32'hdead, 32'h300, 0, 1, 32'h300, 3'd1, 1, 0));
    tbl.push_back(mk(2'b00, 32'h0,   32'h0,   1, 0, 32'h0,   3'd0, 1, 0));
    // fill, drop third bundle, then drain in order
    tbl.push_back(mk(2'b11, 32'h400, 32'h404, 0, 1, 32'h400, 3'd2, 1, 0));
    tbl.push_back(mk(2'b11, 32'h408, 32'h40c, 0, 1, 32'h400, 3'd4, 0, 0));
    tbl.push_back(mk(2'b11, 32'h410, 32'h414, 0, 1, 32'h400, 3'd4, 0, 1));
    tbl.push_back(mk(2'b00, 32'h0,   32'h0,   0, 1, 32'h400, 3'd4, 0, 1));
    tbl.push_back(mk(2'b00, 32'h0,   32'h0,   1, 1, 32'h404, 3'd3, 0, 1));
    tbl.push_back(mk(2'b00, 32'h0,   32'h0,   1, 1, 32'h408, 3'd2, 1, 1));
    tbl.push_back(mk(2'b00, 32'h0,   32'h0,   1, 1, 32'h40c, 3'd1, 1, 1));
    tbl.push_back(mk(2'b00, 32'h0,   32'h0,   1, 0, 32'h0,   3'd0, 1, 1));
    // move wr_ptr to 3 with concurrent push/pop, then a bundle straddling slot 3 -> 0
    tbl.push_back(mk(2'b11, 32'h500, 32'h504, 0, 1, 32'h500, 3'd2, 1, 1));
    tbl.push_back(mk(2'b01, 32'h508, 32'h0,   1, 1, 32'h504, 3'd2, 1, 1));
    tbl.push_back(mk(2'b11, 32'h50c, 32'h510, 1, 1, 32'h508, 3'd3, 0, 1));
    tbl.push_back(mk(2'b00, 32'h0,   32'h0,   1, 1, 32'h50c, 3'd2, 1, 1));
    tbl.push_back(mk(2'b00, 32'h0,   32'h0,   1, 1, 32'h510, 3'd1, 1, 1));
    tbl.push_back(mk(2'b00, 32'h0,   32'h0,   1, 0, 32'h0,   3'd0, 1, 1));

    foreach (tbl[i]) step(tbl[i], i);

    // asynchronous reset with three entries buffered
    drive(2'b11, 32'h600, 32'h604);
    out_ready = 1'b0;
    @(posedge clk); #1;
    drive(2'b01, 32'h608, 32'h0);
    @(posedge clk); #1;
    drive(2'b00, 32'h0, 32'h0);
    check("pre-reset level", 32'(level), 32'd3);
    #2;
    resetn = 1'b0;
    #1;
    check("async reset level", 32'(level), 32'd0);
    check("async reset out_valid", 32'(out_valid), 32'd0);
    check("async reset overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("post-reset level", 32'(level), 32'd0);

`ifdef RVFI_SERIALIZER_ORDER_CHECK_EN
    // trap on first entry suppresses the compare on the next pop
    trap_bits = 2'b01;
    drive(2'b11, 32'h0, 32'h8);
    out_ready = 1'b1;
    @(posedge clk); #1;
    trap_bits = 2'b00;
    drive(2'b00, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("order trap level", 32'(level), 32'd0);
    check("order trap order_error", 32'(order_error), 32'd0);
    reset_pulse();
    drive(2'b11, 32'h0, 32'h8);
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive(2'b00, 32'h0, 32'h0);
    @(posedge clk); #1;
    check("order first pop order_error", 32'(order_error), 32'd0);
    @(posedge clk); #1;
    check("order break order_error", 32'(order_error), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
